// File: rtl/io_access_sequencer_pkg.sv
// io_access_sequencer_pkg: shared FSM encoding, IO window base, default timeout and device offsets
package io_access_sequencer_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;
   localparam logic [31:0] IO_BASE            = 32'hFFFF_FC00;
   localparam int          DEF_TIMEOUT_CYCLES = 255;
   localparam int          DEF_OFFSET_W       = 10;
   localparam logic [9:0]  OFF_SWITCH         = 10'h000;
   localparam logic [9:0]  OFF_LED            = 10'h004;
   localparam logic [9:0]  OFF_SEG            = 10'h008;
   localparam logic [9:0]  OFF_UART           = 10'h00C;
endpackage

// File: rtl/io_access_sequencer_timeout_counter.sv
// io_timeout_counter: 8-bit clear/enable counter; tc flags the LIMIT-th enabled cycle (clk, rst, clr, en -> tc)
module io_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [7:0] count;
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (en) count <= count + 8'd1;
   assign tc = count == 8'(LIMIT - 1);
endmodule

// File: rtl/io_access_sequencer.sv
// io_access_sequencer: stalls the core while an IO load/store runs a req/ack bus cycle (strobes/addr/wdata in; cpu_stall, rdata/rdata_valid, bus_err, dev_* bus out)
module io_access_sequencer
   import io_access_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int OFFSET_W       = DEF_OFFSET_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                io_read,
   input  logic                io_write,
   input  logic [31:0]         addr,
   input  logic [31:0]         wdata,
   output logic                cpu_stall,
   output logic [31:0]         rdata,
   output logic                rdata_valid,
   output logic                bus_err,
   output logic                dev_req,
   output logic                dev_we,
   output logic [OFFSET_W-1:0] dev_addr,
   output logic [31:0]         dev_wdata,
   input  logic                dev_ack,
   input  logic [31:0]         dev_rdata
);
   state_t state, state_n;
   logic we_q;
   logic [OFFSET_W-3:0] off_q;
   logic [31:0] wdata_q;
   logic strobe, misaligned, tc, unused_addr;
   assign strobe = io_read | io_write;
   assign misaligned = addr[1:0] != 2'b00;
   assign unused_addr = ^addr[31:OFFSET_W];
   io_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk(clk),
      .rst(rst),
      .clr(state == ST_REQ),
      .en (state == ST_WAIT),
      .tc (tc)
   );
   always_comb begin
      state_n = state;
      state_n = state == ST_IDLE ? (strobe ? (misaligned ? ST_DONE : ST_REQ) : ST_IDLE)
              : state == ST_REQ  ? ST_WAIT
              : state == ST_WAIT ? ((dev_ack || tc) ? ST_DONE : ST_WAIT)
              : ST_IDLE;
   end
   // Bus outputs are gated by dev_req so the peripheral bus idles at zero between transactions.
   always_comb begin
      dev_req = 1'b0;
      dev_req = state == ST_REQ || state == ST_WAIT;
      cpu_stall = state == ST_IDLE ? strobe : dev_req;
      rdata_valid = state == ST_DONE && !we_q;
      dev_we = dev_req && we_q;
      dev_addr = dev_req ? {off_q, 2'b00} : '0;
      dev_wdata = dev_req ? wdata_q : '0;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         we_q <= 1'b0;
         off_q <= '0;
         wdata_q <= '0;
         rdata <= '0;
         bus_err <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && strobe) begin
            we_q <= io_write;
            off_q <= addr[OFFSET_W-1:2];
            wdata_q <= wdata;
            if (misaligned || (io_read && io_write)) bus_err <= 1'b1;
            if (misaligned && !io_write) rdata <= '0;
         end
         // An ack in the terminal-count cycle still completes normally.
         if (state == ST_WAIT) begin
            if (dev_ack) begin
               if (!we_q) rdata <= dev_rdata;
            end else if (tc) begin
               bus_err <= 1'b1;
               if (!we_q) rdata <= '0;
            end
         end
      end
endmodule

// File: tb/tb_io_access_sequencer.sv
// tb_io_access_sequencer: table-driven and hand-sequenced checks of io_access_sequencer
module tb_io_access_sequencer;
   import io_access_sequencer_pkg::*;
   logic clk = 1'b0;
   logic rst, io_read, io_write, dev_ack;
   logic [31:0] addr, wdata, dev_rdata;
   logic cpu_stall, rdata_valid, bus_err, dev_req, dev_we;
   logic [31:0] rdata, dev_wdata;
   logic [9:0] dev_addr;
   logic t_cpu_stall, t_rdata_valid, t_bus_err, t_dev_req, t_dev_we;
   logic [31:0] t_rdata, t_dev_wdata;
   logic [9:0] t_dev_addr;
   int checks = 0;
   int errors = 0;
   localparam logic [31:0] SW   = IO_BASE + 32'(OFF_SWITCH);
   localparam logic [31:0] LED  = IO_BASE + 32'(OFF_LED);
   localparam logic [31:0] SEG  = IO_BASE + 32'(OFF_SEG);
   localparam logic [31:0] UART = IO_BASE + 32'(OFF_UART);
   always #5 clk = ~clk;
   io_access_sequencer dut (
      .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write), .addr(addr), .wdata(wdata),
      .cpu_stall(cpu_stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
      .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_ack(dev_ack), .dev_rdata(dev_rdata)
   );
   io_access_sequencer #(.TIMEOUT_CYCLES(4)) dut_t (
      .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write), .addr(addr), .wdata(wdata),
      .cpu_stall(t_cpu_stall), .rdata(t_rdata), .rdata_valid(t_rdata_valid), .bus_err(t_bus_err),
      .dev_req(t_dev_req), .dev_we(t_dev_we), .dev_addr(t_dev_addr), .dev_wdata(t_dev_wdata),
      .dev_ack(dev_ack), .dev_rdata(dev_rdata)
   );
   typedef struct {
      logic rst, rd, wr;
      logic [31:0] addr, wdata;
      logic ack;
      logic [31:0] drd;
      logic stall, req, we, valid, err;
      logic [9:0] daddr;
      logic [31:0] dwd, rdata;
   } vec_t;
   vec_t vecs[$];
   function automatic vec_t v(logic r, logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic ack,
                              logic [31:0] drd, logic stall, logic req, logic we, logic valid, logic err,
                              logic [9:0] daddr, logic [31:0] dwd, logic [31:0] rdat);
      vec_t x;
      x.rst = r; x.rd = rd; x.wr = wr; x.addr = a; x.wdata = wd; x.ack = ack; x.drd = drd;
      x.stall = stall; x.req = req; x.we = we; x.valid = valid; x.err = err;
      x.daddr = daddr; x.dwd = dwd; x.rdata = rdat;
      return x;
   endfunction
   function automatic logic [78:0] pk(logic stall, logic req, logic we, logic valid, logic err,
                                      logic [9:0] daddr, logic [31:0] dwd, logic [31:0] rdat);
      return {stall, req, we, valid, err, daddr, dwd, rdat};
   endfunction
   task automatic cyc(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] drd);
      @(posedge clk);
      #1;
      rst = r; io_read = rd; io_write = wr; addr = a; wdata = wd; dev_ack = ack; dev_rdata = drd;
      @(negedge clk);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask
   initial begin
      rst = 1; io_read = 0; io_write = 0; addr = 0; wdata = 0; dev_ack = 0; dev_rdata = 0;
      repeat (2) @(posedge clk);
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,1,0,SW,0,0,0,                1,0,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,                 1,1,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,1,32'hA5,            1,1,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,1,0,10'h000,0,32'hA5));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,0,10'h000,0,32'hA5));
      vecs.push_back(v(0,0,1,LED,32'h0F,0,0,          1,0,0,0,0,10'h000,0,32'hA5));
      for (int i = 0; i < 5; i++)
         vecs.push_back(v(0,0,0,0,0,0,0,              1,1,1,0,0,10'h004,32'h0F,32'hA5));
      vecs.push_back(v(0,0,0,0,0,1,0,                 1,1,1,0,0,10'h004,32'h0F,32'hA5));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,0,10'h000,0,32'hA5));
      vecs.push_back(v(0,1,0,IO_BASE+2,0,0,0,         1,0,0,0,0,10'h000,0,32'hA5));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,1,1,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,1,10'h000,0,0));
      vecs.push_back(v(1,0,0,0,0,0,0,                 0,0,0,0,1,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,1,0,SEG,0,0,0,               1,0,0,0,0,10'h000,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,                 1,1,0,0,0,10'h008,0,0));
      vecs.push_back(v(0,0,0,0,0,1,32'h11,            1,1,0,0,0,10'h008,0,0));
      vecs.push_back(v(0,1,0,UART,0,0,0,              0,0,0,1,0,10'h000,0,32'h11));
      vecs.push_back(v(0,1,0,UART,0,0,0,              1,0,0,0,0,10'h000,0,32'h11));
      vecs.push_back(v(0,0,0,0,0,0,0,                 1,1,0,0,0,10'h00C,0,32'h11));
      vecs.push_back(v(0,0,0,0,0,1,32'h22,            1,1,0,0,0,10'h00C,0,32'h11));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,1,0,10'h000,0,32'h22));
      vecs.push_back(v(0,1,1,LED,32'hDEADBEEF,0,0,    1,0,0,0,0,10'h000,0,32'h22));
      vecs.push_back(v(0,0,0,0,0,0,0,                 1,1,1,0,1,10'h004,32'hDEADBEEF,32'h22));
      vecs.push_back(v(0,0,0,0,0,1,32'h99,            1,1,1,0,1,10'h004,32'hDEADBEEF,32'h22));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,1,10'h000,0,32'h22));
      vecs.push_back(v(0,0,0,0,0,1,32'h77,            0,0,0,0,1,10'h000,0,32'h22));
      vecs.push_back(v(0,0,0,0,0,0,0,                 0,0,0,0,1,10'h000,0,32'h22));
      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].drd);
         chk($sformatf("vec%0d", i),
             pk(cpu_stall, dev_req, dev_we, rdata_valid, bus_err, dev_addr, dev_wdata, rdata),
             pk(vecs[i].stall, vecs[i].req, vecs[i].we, vecs[i].valid, vecs[i].err,
                vecs[i].daddr, vecs[i].dwd, vecs[i].rdata));
      end
      cyc(0, 1, 0, SW, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("midwait_req", 79'(dev_req), 79'(1));
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'hEE);
      chk("rst_outputs", pk(cpu_stall, dev_req, dev_we, rdata_valid, bus_err, dev_addr, dev_wdata, rdata), '0);
      idle();
      chk("late_ack", pk(cpu_stall, dev_req, dev_we, rdata_valid, bus_err, dev_addr, dev_wdata, rdata), '0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle();
      chk("t_reset", pk(t_cpu_stall, t_dev_req, t_dev_we, t_rdata_valid, t_bus_err, t_dev_addr, t_dev_wdata, t_rdata), '0);
      cyc(0, 1, 0, SW, 0, 0, 0);
      idle();
      repeat (3) idle();
      cyc(0, 0, 0, 0, 0, 1, 32'h3C);
      chk("ack_at_tc_req", 79'(t_dev_req), 79'(1));
      idle();
      chk("ack_at_tc_done", pk(t_cpu_stall, t_dev_req, 1'b0, t_rdata_valid, t_bus_err, 10'h0, 32'h0, t_rdata),
          pk(0, 0, 0, 1, 0, 10'h0, 32'h0, 32'h3C));
      idle();
      cyc(0, 1, 0, SW, 0, 0, 0);
      idle();
      for (int i = 0; i < 4; i++) begin
         idle();
         chk($sformatf("tmo_wait%0d_req", i), 79'(t_dev_req), 79'(1));
      end
      idle();
      chk("tmo_done", pk(t_cpu_stall, t_dev_req, 1'b0, t_rdata_valid, t_bus_err, 10'h0, 32'h0, t_rdata),
          pk(0, 0, 0, 1, 1, 10'h0, 32'h0, 32'h0));
      idle();
      chk("tmo_sticky", pk(t_cpu_stall, t_dev_req, 1'b0, t_rdata_valid, t_bus_err, 10'h0, 32'h0, t_rdata),
          pk(0, 0, 0, 0, 1, 10'h0, 32'h0, 32'h0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_access_sequencer.md
Name: io_access_sequencer

Overview:
- Multi-cycle sequencer for the memory-mapped IO window at 0xFFFFFC00–0xFFFFFFFF.
- Accepts one-cycle IORead/IOWrite strobes from the instruction decoder, together with the ALU-computed address and the store data.
- Runs a req/ack transaction on the peripheral bus and stalls the core until the transaction completes or times out.
- Sits between the control decoder, the register-file writeback mux and the peripheral bus (switches, LEDs, seven-segment display, UART).

Parameters:
- TIMEOUT_CYCLES, 255, cycles in WAIT without dev_ack before abort; legal range 1–255.
- OFFSET_W, 10, width of the device offset (IO window is 1 KiB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- io_read  in  1  decoder IORead (load to IO address).
- io_write  in  1  decoder IOWrite (store to IO address).
- addr  in  32  ALU result (byte address).
- wdata  in  32  store data (rs2).
- cpu_stall  out  1  hold PC and pipeline registers while high.
- rdata  out  32  load result for the writeback mux.
- rdata_valid  out  1  one-cycle qualifier on rdata.
- bus_err  out  1  sticky error flag; set on timeout or misalignment.
- dev_req  out  1  bus request; held until ack.
- dev_we  out  1  1 = write, 0 = read; stable while dev_req is high.
- dev_addr  out  OFFSET_W  addr[OFFSET_W-1:0], word aligned.
- dev_wdata  out  32  write data; stable while dev_req is high.
- dev_ack  in  1  device completion; single-cycle pulse.
- dev_rdata  in  32  read data; valid in the dev_ack cycle.

Behaviour:
- Reset values: state=IDLE; all outputs 0; timeout counter 0; bus_err cleared. rst has priority over every other event, including mid-transaction. An abandoned dev_ack arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE. Encoding is 2 bits, registered.
- IDLE:
  - If io_read or io_write is high, capture we=io_write, the offset and wdata, then go to REQ.
  - If both are high together, treat as a write and set bus_err.
  - If addr[1:0] != 0, set bus_err, skip the bus cycle and go straight to DONE with rdata=0.
  - cpu_stall is combinational here: io_read|io_write. This freezes the core in the same cycle the request appears.
- REQ (1 cycle): dev_req=1, counter cleared, go to WAIT. cpu_stall=1.
- WAIT:
  - dev_req=1, cpu_stall=1, counter increments each cycle.
  - On dev_ack: capture dev_rdata into rdata if this is a read, then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without dev_ack: drop dev_req, set bus_err, rdata=0, go to DONE.
  - If dev_ack and timeout coincide, ack wins.
- DONE (1 cycle):
  - cpu_stall=0, so the core commits and advances PC on this edge.
  - rdata_valid=1 for reads only.
  - Returns to IDLE unconditionally. Decoder strobes are ignored in DONE because they still belong to the retiring instruction.
- dev_ack outside WAIT is ignored.
- rdata holds its value until the next captured read.
- Minimum latency with ack in the first WAIT cycle: request seen in cycle 0 → REQ cycle 1 → WAIT cycle 2 (ack) → DONE cycle 3. Total 3 stall cycles.
- bus_err clears only on rst.

Decomposition:
- Shared package holds:
  - the state encoding constants;
  - IO_BASE = 0xFFFFFC00;
  - the default TIMEOUT_CYCLES;
  - the device offset constants (switch 0x000, LED 0x004, seg 0x008, UART 0x00C).
- One sub-module is natural: io_timeout_counter (8-bit clear/enable counter with terminal-count output).

Test Plan:
- Read, ack on the first WAIT cycle: io_read=1, addr=0xFFFFFC00, dev_rdata=0x0000_00A5 → dev_req high for 2 cycles, dev_addr=0x000, cpu_stall high for 3 cycles, rdata=0xA5 with rdata_valid=1 in the DONE cycle.
- Write with 5-cycle ack delay: io_write=1, addr=0xFFFFFC04, wdata=0x0F → dev_we=1 and dev_wdata=0x0F stable for 6 cycles, rdata_valid stays 0, cpu_stall drops in DONE.
- Timeout with TIMEOUT_CYCLES=4 and no ack → dev_req drops after 4 WAIT cycles, bus_err=1, rdata=0, core released.
- Misaligned read, addr=0xFFFFFC02 → no dev_req, bus_err=1, DONE one cycle after IDLE.
- Reset mid-WAIT, then a late dev_ack → all outputs return to 0 the next cycle, state=IDLE, the late ack produces no rdata_valid.
- Simultaneous io_read=io_write=1 → a write transaction is issued and bus_err=1. Back-to-back reads on consecutive instructions each complete with a separate DONE pulse.
